// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//
// Runs one timed scoring round for a single player at a time. A start request
// in IDLE latches the player index, clears the score and opens an ARM
// countdown. PLAY then stays open for a fixed window, counting rising edges of
// the player's hit button into a saturating 8-bit score. DONE lasts one cycle
// and pulses round_done. An abort in ARM or PLAY drops straight back to IDLE.
//
// Parameters
//   ARM_CYCLES    countdown length in clocks before play opens (>= 1)
//   ROUND_CYCLES  play-window length in clocks (>= 1, < 2^24)
//
// Ports
//   clk          system clock, rising edge
//   clr_n        synchronous active-low reset
//   start        level, request a new round (honoured in IDLE only)
//   user_sel     player index captured on an accepted start
//   hit          raw button level, synchronous to clk
//   abort        level, cancels a round in ARM or PLAY
//   enable       one-hot of the active player while in PLAY, else zero
//   score_count  current / final round score, saturates at 255
//   user_id      player index of the current / last round
//   round_done   one-cycle pulse on normal round completion
//   busy         high while in ARM or PLAY
// -----------------------------------------------------------------------------
module score_tracker #(
    parameter int ARM_CYCLES   = 16,
    parameter int ROUND_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic [2:0] user_sel,
    input  logic       hit,
    input  logic       abort,
    output logic [7:0] enable,
    output logic [7:0] score_count,
    output logic [2:0] user_id,
    output logic       round_done,
    output logic       busy
);

    localparam int TIMER_W = 24;
    localparam logic [TIMER_W-1:0] ARM_LOAD   = TIMER_W'(ARM_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ROUND_LOAD = TIMER_W'(ROUND_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PLAY,
        DONE
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               hit_q;     // hit sampled once into the clock domain
    logic               hit_prev;  // previous sample of hit_q
    logic               hit_rise;

    // A press counts once, on the cycle the registered level goes 0 -> 1.
    // A level already high when PLAY opens produces no rise and is ignored.
    assign hit_rise = hit_q & ~hit_prev;

    // NOTE: every register below is written with <= so all of them see the
    // pre-edge values of each other; blocking assignments here would let the
    // edge detector and the score update race against each other.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state       <= IDLE;
            timer       <= '0;
            score_count <= '0;
            user_id     <= '0;
            hit_q       <= 1'b0;
            hit_prev    <= 1'b0;
        end else begin
            hit_q    <= hit;
            hit_prev <= hit_q;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ARM;
                        user_id     <= user_sel;
                        score_count <= '0;
                        timer       <= ARM_LOAD;
                    end
                end

                ARM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (timer == '0) begin
                        state <= PLAY;
                        timer <= ROUND_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                PLAY: begin
                    // Abort beats both a same-cycle hit and window expiry:
                    // the score is frozen and DONE is never entered.
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        if (hit_rise && score_count != 8'hFF) begin
                            score_count <= score_count + 8'd1;
                        end
                        if (timer == '0) begin
                            state <= DONE;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from the state register, so they change only
    // on clock edges and need no extra pipeline stage.
    // NOTE: each output gets a default before the conditional override so the
    // block stays purely combinational with no inferred latch.
    always_comb begin
        enable     = '0;
        round_done = 1'b0;
        busy       = 1'b0;
        if (state == PLAY) begin
            enable = 8'b1 << user_id;
        end
        if (state == DONE) begin
            round_done = 1'b1;
        end
        if (state == ARM || state == PLAY) begin
            busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// -----------------------------------------------------------------------------
// tb_score_tracker
//
// Two instances share one stimulus stream: dut_a uses a short play window
// (ARM 4, ROUND 20) for the round-timing scenarios, dut_b a long one
// (ARM 4, ROUND 700) so a single round can reach score saturation.
// A behavioural model tracks each round as "cycles elapsed since start" and
// derives the phase from that count; it is compared against both instances
// on every falling edge once reset has been applied. Directed scenarios add
// literal expectations on top.
// -----------------------------------------------------------------------------
module tb_score_tracker;

    localparam int ARM_C = 4;
    localparam int RND_A = 20;
    localparam int RND_B = 700;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start;
    logic [2:0] user_sel;
    logic       hit;
    logic       abort;

    logic [7:0] en_a, sc_a, en_b, sc_b;
    logic [2:0] uid_a, uid_b;
    logic       rd_a, bs_a, rd_b, bs_b;

    always #5 clk = ~clk;

    score_tracker #(.ARM_CYCLES(ARM_C), .ROUND_CYCLES(RND_A)) dut_a (
        .clk(clk), .clr_n(clr_n), .start(start), .user_sel(user_sel),
        .hit(hit), .abort(abort), .enable(en_a), .score_count(sc_a),
        .user_id(uid_a), .round_done(rd_a), .busy(bs_a)
    );

    score_tracker #(.ARM_CYCLES(ARM_C), .ROUND_CYCLES(RND_B)) dut_b (
        .clk(clk), .clr_n(clr_n), .start(start), .user_sel(user_sel),
        .hit(hit), .abort(abort), .enable(en_b), .score_count(sc_b),
        .user_id(uid_b), .round_done(rd_b), .busy(bs_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // in_round : a round has been accepted and not yet left DONE / aborted
    // t        : clocks elapsed since the accepted start (0 = first ARM cycle)
    bit m_in    [2];
    int m_t     [2];
    int m_score [2];
    int m_uid   [2];
    bit m_h1    [2];  // hit as sampled on the previous edge
    bit m_h2    [2];  // hit as sampled two edges ago
    int m_round [2] = '{RND_A, RND_B};
    bit m_valid = 1'b0;

    function automatic void model_step(input int k);
        bit rise;
        if (!clr_n) begin
            m_in[k] = 1'b0; m_t[k] = 0; m_score[k] = 0; m_uid[k] = 0;
            m_h1[k] = 1'b0; m_h2[k] = 1'b0;
            return;
        end
        rise = m_h1[k] && !m_h2[k];
        if (!m_in[k]) begin
            if (start) begin
                m_in[k] = 1'b1; m_t[k] = 0; m_uid[k] = int'(user_sel); m_score[k] = 0;
            end
        end else if (m_t[k] < ARM_C) begin
            if (abort) m_in[k] = 1'b0; else m_t[k]++;
        end else if (m_t[k] < ARM_C + m_round[k]) begin
            if (abort) m_in[k] = 1'b0;
            else begin
                if (rise && m_score[k] < 255) m_score[k]++;
                m_t[k]++;
            end
        end else begin
            m_in[k] = 1'b0;  // DONE always completes
        end
        m_h2[k] = m_h1[k];
        m_h1[k] = hit;
    endfunction

    function automatic logic [7:0] exp_enable(input int k);
        if (m_in[k] && m_t[k] >= ARM_C && m_t[k] < ARM_C + m_round[k])
            return 8'(1 << m_uid[k]);
        return 8'h00;
    endfunction

    function automatic logic exp_busy(input int k);
        return m_in[k] && m_t[k] < ARM_C + m_round[k];
    endfunction

    function automatic logic exp_done(input int k);
        return m_in[k] && m_t[k] == ARM_C + m_round[k];
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (!clr_n) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("a.enable",      32'(en_a),  32'(exp_enable(0)));
            check("a.score_count", 32'(sc_a),  32'(m_score[0]));
            check("a.user_id",     32'(uid_a), 32'(m_uid[0]));
            check("a.round_done",  32'(rd_a),  32'(exp_done(0)));
            check("a.busy",        32'(bs_a),  32'(exp_busy(0)));
            check("b.enable",      32'(en_b),  32'(exp_enable(1)));
            check("b.score_count", 32'(sc_b),  32'(m_score[1]));
            check("b.user_id",     32'(uid_b), 32'(m_uid[1]));
            check("b.round_done",  32'(rd_b),  32'(exp_done(1)));
            check("b.busy",        32'(bs_b),  32'(exp_busy(1)));
        end
    end

    // Counters on dut_a for the directed timing scenarios.
    int en_cnt   = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (en_a != 8'h00) en_cnt++;
        if (rd_a) done_cnt++;
    end

    // ---------------- driver helpers ----------------
    // Inputs change 2 time units after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Waits for the first PLAY cycle of the chosen instance, then returns
    // 2 time units into the second PLAY cycle.
    task automatic wait_play(input int k);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if ((k == 0 ? en_a : en_b) != 8'h00) found = 1'b1;
        end
        check("wait_play", 32'(found), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1; tick(1);
            hit = 1'b0; tick(1);
        end
    endtask

    task automatic kick(input logic [2:0] sel);
        user_sel = sel; start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic abort_pulse();
        abort = 1'b1; tick(1); abort = 1'b0; tick(1);
    endtask

    initial begin
        bit found;
        clr_n = 1'b0; start = 1'b0; hit = 1'b0; abort = 1'b0; user_sel = 3'd0;
        tick(2);
        clr_n = 1'b1;

        // Reset state
        check("reset enable", 32'(en_a), 32'h0);
        check("reset score",  32'(sc_a), 32'h0);
        check("reset busy",   32'(bs_a), 32'h0);
        check("reset uid",    32'(uid_b), 32'h0);

        // Basic round: player 5, seven separated presses
        en_cnt = 0; done_cnt = 0;
        kick(3'd5);
        wait_play(0);
        pulses(7);
        tick(20);
        check("basic enable cycles", 32'(en_cnt), 32'd20);
        check("basic done pulses",   32'(done_cnt), 32'd1);
        check("basic score",         32'(sc_a), 32'd7);
        check("basic uid",           32'(uid_a), 32'd5);
        check("basic enable after",  32'(en_a), 32'h0);
        abort_pulse();
        check("abort idle no effect busy", 32'(bs_a), 32'd0);
        check("abort b busy", 32'(bs_b), 32'd0);

        // Held level: high across PLAY entry, then one long press
        user_sel = 3'd1; start = 1'b1; hit = 1'b1; tick(1); start = 1'b0;
        wait_play(0);
        tick(3);
        check("held at entry score", 32'(sc_a), 32'd0);
        hit = 1'b0; tick(2);
        hit = 1'b1; tick(10);
        hit = 1'b0; tick(2);
        check("long press score", 32'(sc_a), 32'd1);
        tick(5);
        abort_pulse();

        // Abort on PLAY cycle 5 together with a hit edge
        done_cnt = 0;
        kick(3'd3);
        wait_play(0);                 // in PLAY cycle 2
        hit = 1'b1; tick(1);          // edge seen in cycle 3, counted
        hit = 1'b0; tick(1);          // cycle 4
        hit = 1'b1; tick(1);          // cycle 5: edge of this press
        hit = 1'b0; abort = 1'b1; tick(1);
        abort = 1'b0;
        check("abort busy",  32'(bs_a), 32'd0);
        check("abort enable", 32'(en_a), 32'h0);
        tick(30);
        check("abort score kept", 32'(sc_a), 32'd1);
        check("abort no done",    32'(done_cnt), 32'd0);

        // Abort on the final PLAY cycle
        en_cnt = 0; done_cnt = 0;
        kick(3'd4);
        wait_play(0);                 // PLAY cycle 2
        tick(18);                     // PLAY cycle 20
        abort = 1'b1; tick(1); abort = 1'b0;
        tick(3);
        check("late abort enable cycles", 32'(en_cnt), 32'd20);
        check("late abort no done",       32'(done_cnt), 32'd0);
        check("late abort busy",          32'(bs_a), 32'd0);

        // Saturation on the long-window instance
        kick(3'd0);
        wait_play(1);
        pulses(330);
        check("saturate score", 32'(sc_b), 32'd255);
        pulses(10);
        check("saturate hold",  32'(sc_b), 32'd255);
        abort_pulse();
        check("saturate kept after abort", 32'(sc_b), 32'd255);

        // Reset mid-PLAY with score 12
        kick(3'd6);
        wait_play(1);
        pulses(12);
        tick(3);
        check("pre-reset score", 32'(sc_b), 32'd12);
        clr_n = 1'b0; tick(1); clr_n = 1'b1;
        check("mid reset score",  32'(sc_b), 32'd0);
        check("mid reset enable", 32'(en_b), 32'h0);
        check("mid reset uid",    32'(uid_b), 32'd0);
        check("mid reset busy",   32'(bs_b), 32'd0);
        check("mid reset done",   32'(rd_b), 32'd0);
        kick(3'd7);
        check("restart busy", 32'(bs_b), 32'd1);
        check("restart uid",  32'(uid_b), 32'd7);
        tick(3);
        abort_pulse();

        // Start ignored in ARM, PLAY and DONE
        en_cnt = 0; done_cnt = 0;
        kick(3'd2);
        user_sel = 3'd6;
        start = 1'b1; tick(1); start = 1'b0;   // in ARM
        wait_play(0);
        start = 1'b1; tick(1); start = 1'b0;   // in PLAY
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rd_a) found = 1'b1;
        end
        check("wait done", 32'(found), 32'd1);
        #1 start = 1'b1;                        // during DONE
        @(posedge clk); #2 start = 1'b0;
        tick(3);
        check("ignored start uid",      32'(uid_a), 32'd2);
        check("ignored start enable",   32'(en_cnt), 32'd20);
        check("ignored start done",     32'(done_cnt), 32'd1);
        check("ignored start idle",     32'(bs_a), 32'd0);
        abort_pulse();

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            user_sel = 3'($urandom_range(0, 7));
            hit      = 1'($urandom_range(0, 1));
            abort    = ($urandom_range(0, 63) == 0);
            clr_n    = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        clr_n = 1'b1; start = 1'b0; abort = 1'b0; hit = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
